sdram_rd_arb: RTL

Round-robin read arbiter that shares the single SDRAM Avalon-MM read master among `pNUM_REQ` renderer requesters (BG layers, later sprites) inside VID_MIXER. It grants one requester at a time and issues exactly one SDRAM read per grant. Read data returns to the granted requester only. Each requester sees a private Avalon-style read port, so BG instances need no changes.

---
 rtl/sdram_rd_arb_pkg.sv | 10 +
 rtl/sdram_rd_arb_pick.sv | 26 ++
 rtl/sdram_rd_arb.sv | 80 ++++++++
 3 files changed

// File: rtl/sdram_rd_arb_pkg.sv
// sdram_rd_arb_pkg: shared address type and requester count for the SDRAM read arbiter
package sdram_rd_arb_pkg;

    typedef logic [23:0] tADDR;

    localparam int cBG_NUM           = 4;
    localparam int cSPR_NUM          = 0;
    localparam int cSDRAM_RD_REQ_NUM = cBG_NUM + cSPR_NUM;

endpackage

// File: rtl/sdram_rd_arb_pick.sv
// rr_arb_pick: combinational round-robin picker, lowest index after the last grant wins
module rr_arb_pick #(
    parameter int pNUM_REQ = 4,
    parameter int pIDX_W   = $clog2(pNUM_REQ)
) (
    input  logic [pNUM_REQ-1:0] iREQ,
    input  logic [pIDX_W-1:0]   iLAST,
    output logic [pIDX_W-1:0]   oGRANT,
    output logic                oANY
);

    logic [pIDX_W-1:0] w_idx;

    // Walk from the farthest candidate back to last+1 so the closest requester overwrites
    always_comb begin
        oGRANT = '0;
        w_idx  = '0;
        for (int k = pNUM_REQ; k >= 1; k--) begin
            w_idx = pIDX_W'((int'(iLAST) + k) % pNUM_REQ);
            if (iREQ[w_idx]) oGRANT = w_idx;
        end
    end

    assign oANY = |iREQ;

endmodule

// File: rtl/sdram_rd_arb.sv
// sdram_rd_arb: round-robin sharing of one SDRAM read master among several requesters
module sdram_rd_arb
    import sdram_rd_arb_pkg::*;
#(
    parameter int pNUM_REQ = cSDRAM_RD_REQ_NUM
) (
    input  logic                      iCLOCK,
    input  logic                      iRESET,
    input  tADDR [pNUM_REQ-1:0]       iREQ_ADDRESS,
    input  logic [pNUM_REQ-1:0]       iREQ_READ,
    output logic [pNUM_REQ-1:0]       oREQ_WAIT_REQUEST,
    output logic [15:0]               oREQ_READ_DATA,
    output logic [pNUM_REQ-1:0]       oREQ_READ_DATA_VALID,
    output tADDR                      oSDRAM_ADDRESS,
    output logic                      oSDRAM_READ,
    input  logic                      iSDRAM_WAIT_REQUEST,
    input  logic [15:0]               iSDRAM_READ_DATA,
    input  logic                      iSDRAM_READ_DATA_VALID
);

    localparam int cIDX_W = $clog2(pNUM_REQ);

    typedef enum logic [1:0] {sIDLE, sCMD, sDATA} tARB_STATE;

    tARB_STATE         rSTATE, wNEXT;
    logic [cIDX_W-1:0] rGRANT, rLAST, wPICK;
    tADDR              rADDR;
    logic              wANY;

    rr_arb_pick #(.pNUM_REQ(pNUM_REQ), .pIDX_W(cIDX_W)) u_pick (
        .iREQ   (iREQ_READ),
        .iLAST  (rLAST),
        .oGRANT (wPICK),
        .oANY   (wANY)
    );

    // State register and grant/address latch, captured only when leaving idle
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            rSTATE <= sIDLE;
            rGRANT <= '0;
            rLAST  <= cIDX_W'(pNUM_REQ - 1);
            rADDR  <= '0;
        end else begin
            rSTATE <= wNEXT;
            if (rSTATE == sIDLE && wANY) begin
                rGRANT <= wPICK;
                rLAST  <= wPICK;
                rADDR  <= iREQ_ADDRESS[wPICK];
            end
        end
    end

    // Next state plus command, waitrequest and per-requester data strobe decode
    always_comb begin
        wNEXT                = rSTATE;
        oSDRAM_READ          = 1'b0;
        oREQ_WAIT_REQUEST    = '1;
        oREQ_READ_DATA_VALID = '0;
        case (rSTATE)
            sIDLE: if (wANY) wNEXT = sCMD;
            sCMD: begin
                oSDRAM_READ = 1'b1;
                if (!iSDRAM_WAIT_REQUEST) begin
                    wNEXT                     = sDATA;
                    oREQ_WAIT_REQUEST[rGRANT] = 1'b0;
                end
            end
            sDATA: if (iSDRAM_READ_DATA_VALID) begin
                oREQ_READ_DATA_VALID[rGRANT] = 1'b1;
                wNEXT                        = sIDLE;
            end
            default: wNEXT = sIDLE;
        endcase
    end

    assign oSDRAM_ADDRESS = rADDR;
    assign oREQ_READ_DATA = iSDRAM_READ_DATA;

endmodule
